// File: rtl/cmp_pkg.sv
// Shared codes, FSM encoding and code-legality helper for the comparator result
// tally stage.
package cmp_pkg;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  function automatic logic is_onehot3(input logic [2:0] code);
    logic legal;
    case (code)
      RES_GT, RES_EQ, RES_LT: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cmp_result_tally_sat_counter.sv
// Saturating up-counter; clr restarts the count, and clr together with inc
// restarts it at one (used to begin a new run).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = {W{1'b1}};

  // count register: restart on clr, otherwise increment until the ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1'b1) : '0;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + W'(1'b1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/cmp_result_tally.sv
// Windowed tally of the comparator result stream: per-code counts, illegal-code
// count and longest identical run, emitted as one record per WIN_LEN samples.
module cmp_result_tally
  import cmp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic [CNT_W-1:0] out_max_run
);

  localparam int              SC_W     = $clog2(WIN_LEN + 1);
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r;
  logic [SC_W-1:0]  smp_cnt_r;
  logic [2:0]       last_code_r;
  logic [CNT_W-1:0] max_run_r;
  logic [CNT_W-1:0] cur_run_s;
  logic [CNT_W-1:0] next_run_s;
  logic             acc_s;
  logic             xfer_s;
  logic             wipe_s;
  logic             legal_s;
  logic             same_s;

  assign in_ready    = (state_r == ST_ACCUM);
  assign out_valid   = (state_r == ST_REPORT);
  assign out_max_run = max_run_r;

  // A sample arriving together with clear is dropped.
  assign acc_s   = in_valid & in_ready & ~clear;
  assign xfer_s  = out_valid & out_ready;
  assign wipe_s  = clear | xfer_s;
  assign legal_s = is_onehot3(in_res);
  // last_code_r holds 000 after a window start or an illegal code, which never matches a legal code
  assign same_s  = legal_s & (in_res == last_code_r);

  // run length the current sample produces, used to update the maximum
  always_comb begin
    next_run_s = '0;
    if (!legal_s) begin
      next_run_s = '0;
    end else if (same_s && (cur_run_s != CNT_MAX)) begin
      next_run_s = cur_run_s + CNT_W'(1'b1);
    end else if (same_s) begin
      next_run_s = CNT_MAX;
    end else begin
      next_run_s = CNT_W'(1'b1);
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wipe_s),
    .inc   (acc_s & (in_res == RES_GT)),
    .q     (out_gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wipe_s),
    .inc   (acc_s & (in_res == RES_EQ)),
    .q     (out_eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wipe_s),
    .inc   (acc_s & (in_res == RES_LT)),
    .q     (out_lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wipe_s),
    .inc   (acc_s & ~legal_s),
    .q     (out_err_cnt)
  );

  // A new or illegal code restarts the run: at one when legal, at zero otherwise.
  sat_counter #(.W(CNT_W)) u_cur_run (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wipe_s | (acc_s & ~same_s)),
    .inc   (acc_s & legal_s),
    .q     (cur_run_s)
  );

  // window FSM with sample counter, last-code and maximum-run tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACCUM;
      smp_cnt_r   <= '0;
      last_code_r <= 3'b000;
      max_run_r   <= '0;
    end else if (wipe_s) begin
      state_r     <= ST_ACCUM;
      smp_cnt_r   <= '0;
      last_code_r <= 3'b000;
      max_run_r   <= '0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (acc_s) begin
            last_code_r <= legal_s ? in_res : 3'b000;
            max_run_r   <= (next_run_s > max_run_r) ? next_run_s : max_run_r;
            if (smp_cnt_r == LAST_IDX) begin
              state_r   <= ST_REPORT;
              smp_cnt_r <= smp_cnt_r;
            end else begin
              state_r   <= ST_ACCUM;
              smp_cnt_r <= smp_cnt_r + SC_W'(1'b1);
            end
          end else begin
            state_r     <= ST_ACCUM;
            smp_cnt_r   <= smp_cnt_r;
            last_code_r <= last_code_r;
            max_run_r   <= max_run_r;
          end
        end
        ST_REPORT: begin
          state_r     <= ST_REPORT;
          smp_cnt_r   <= smp_cnt_r;
          last_code_r <= last_code_r;
          max_run_r   <= max_run_r;
        end
        default: begin
          state_r     <= ST_ACCUM;
          smp_cnt_r   <= '0;
          last_code_r <= 3'b000;
          max_run_r   <= '0;
        end
      endcase
    end
  end

endmodule
